// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: operation encodings,
// slot state and requester id types.
package alu_arb_pkg;

  localparam int ALU_DW = 32;

  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SUB  = 5'd1;
  localparam logic [4:0] SEL_AND  = 5'd2;
  localparam logic [4:0] SEL_OR   = 5'd3;
  localparam logic [4:0] SEL_XOR  = 5'd4;
  localparam logic [4:0] SEL_SLL  = 5'd5;
  localparam logic [4:0] SEL_SRL  = 5'd6;
  localparam logic [4:0] SEL_SRA  = 5'd7;
  localparam logic [4:0] SEL_SLT  = 5'd8;
  localparam logic [4:0] SEL_SLTU = 5'd9;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational datapath ALU shared by both requesters; undefined selects
// produce zero.
module alu_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic [4:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] f,
  output logic          z
);

  localparam int SW = $clog2(DW);

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    f = '0;
    case (sel)
      SEL_ADD:  f = a + b;
      SEL_SUB:  f = a - b;
      SEL_AND:  f = a & b;
      SEL_OR:   f = a | b;
      SEL_XOR:  f = a ^ b;
      SEL_SLL:  f = a << sh;
      SEL_SRL:  f = a >> sh;
      SEL_SRA:  f = DW'($signed(a) >>> sh);
      SEL_SLT:  f = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      SEL_SLTU: f = {{(DW-1){1'b0}}, a < b};
      default:  f = '0;
    endcase
  end

  assign z = (f == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU with a single registered
// result slot. Define ALU_ARB_RR_EN for round-robin; default is fixed priority (req0).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW = ALU_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [4:0]    req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [4:0]    req1_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_f,
  output logic          rsp_z
);

  arb_state_e    state_q, state_d;
  logic [DW-1:0] rsp_f_q, rsp_f_d;
  logic          rsp_z_q, rsp_z_d;
  req_id_t       rsp_id_q, rsp_id_d;

  logic          prefer0, slot_free, grant0, grant1, accept;
  logic [4:0]    alu_sel;
  logic [DW-1:0] alu_a, alu_b, alu_f;
  logic          alu_z;

`ifdef ALU_ARB_RR_EN
  req_id_t rr_q, rr_d;
  assign prefer0 = (rr_q == 1'b0);
`else
  assign prefer0 = 1'b1;
`endif

  // Grant depends only on the valids, never on operand data.
  always_comb begin
    slot_free  = (state_q == EMPTY) || rsp_ready;
    grant0     = req0_valid && (!req1_valid || prefer0);
    grant1     = req1_valid && (!req0_valid || !prefer0);
    req0_ready = grant0 && slot_free && rst_n;
    req1_ready = grant1 && slot_free && rst_n;
    accept     = req0_ready || req1_ready;
    alu_sel    = grant1 ? req1_sel : req0_sel;
    alu_a      = grant1 ? req1_a   : req0_a;
    alu_b      = grant1 ? req1_b   : req0_b;
  end

  alu_arbiter_alu #(.DW(DW)) u_alu (
    .sel (alu_sel),
    .a   (alu_a),
    .b   (alu_b),
    .f   (alu_f),
    .z   (alu_z)
  );

  always_comb begin
    state_d  = state_q;
    rsp_f_d  = rsp_f_q;
    rsp_z_d  = rsp_z_q;
    rsp_id_d = rsp_id_q;
    if (accept) begin
      state_d  = FULL;
      rsp_f_d  = alu_f;
      rsp_z_d  = alu_z;
      rsp_id_d = req1_ready;
    end else if (state_q == FULL && rsp_ready) begin
      state_d  = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rsp_f_q  <= '0;
      rsp_z_q  <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsp_f_q  <= rsp_f_d;
      rsp_z_q  <= rsp_z_d;
      rsp_id_q <= rsp_id_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  // After each accept the loser becomes the preferred requester.
  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = !req1_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  assign rsp_valid = (state_q == FULL);
  assign rsp_f     = rsp_f_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard of expected results pushed
// at accept time and popped when the result is consumed.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_f;
  logic [4:0]  req0_sel = 0, req1_sel = 0;

  typedef struct {
    logic        id;
    logic [31:0] f;
    logic        z;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_z(rsp_z)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] alu_model(logic [4:0] sel, logic [31:0] a, logic [31:0] b);
    case (sel)
      SEL_ADD:  return a + b;
      SEL_SUB:  return a - b;
      SEL_AND:  return a & b;
      SEL_OR:   return a | b;
      SEL_XOR:  return a ^ b;
      SEL_SLL:  return a << b[4:0];
      SEL_SRL:  return a >> b[4:0];
      SEL_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      SEL_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SEL_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic push_exp(input logic id, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    x.id = id;
    x.f  = alu_model(sel, a, b);
    x.z  = (x.f == 32'd0);
    sbq.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_z, rsp_f} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b id=%b z=%b f=%h, required all zero", rsp_valid, rsp_id, rsp_z, rsp_f);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
    end
    req1_valid = 1'b0;
  endtask

  // First cycle out of reset must accept; req0 5+7.
  task automatic test_single();
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_sel = SEL_ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
    end
    push_exp(1'b0, SEL_ADD, 32'd5, 32'd7);
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL single_rsp: rsp_valid=%b queued=%0d, required valid result", rsp_valid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
        errors++;
        $display("FAIL single_rsp: id=%b f=%h z=%b, required id=%b f=%h z=%b", rsp_id, rsp_f, rsp_z, e.id, e.f, e.z);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_zero_flag();
    req1_valid = 1'b1; req1_sel = SEL_SUB; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL zero_ready: ready0=%b ready1=%b, required 0 1", req0_ready, req1_ready);
    end
    push_exp(1'b1, SEL_SUB, 32'd9, 32'd9);
    @(negedge clk);
    req1_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL zero_rsp: rsp_valid=%b queued=%0d, required valid result", rsp_valid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
        errors++;
        $display("FAIL zero_rsp: id=%b f=%h z=%b, required id=%b f=%h z=%b", rsp_id, rsp_f, rsp_z, e.id, e.f, e.z);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    logic [3:0] exp_ids;
    logic       w;
`ifdef ALU_ARB_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
          errors++;
          $display("FAIL conflict_rsp%0d: rsp_valid=%b queued=%0d, required valid result", i, rsp_valid, sbq.size());
        end else begin
          e = sbq.pop_front();
          if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
            errors++;
            $display("FAIL conflict_rsp%0d: id=%b f=%h, required id=%b f=%h", i, rsp_id, rsp_f, e.id, e.f);
          end
        end
      end
      req0_valid = 1'b1; req0_sel = SEL_ADD; req0_a = 32'd1;  req0_b = 32'd2;
      req1_valid = 1'b1; req1_sel = SEL_ADD; req1_a = 32'd10; req1_b = 32'd20;
      #1;
      w = exp_ids[i];
      checks++;
      if ({req0_ready, req1_ready} !== {~w, w}) begin
        errors++;
        $display("FAIL conflict_grant%0d: ready0=%b ready1=%b, required %b %b", i, req0_ready, req1_ready, ~w, w);
      end
      if (w) push_exp(1'b1, SEL_ADD, 32'd10, 32'd20);
      else   push_exp(1'b0, SEL_ADD, 32'd1, 32'd2);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL conflict_rsp4: rsp_valid=%b queued=%0d, required valid result", rsp_valid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
        errors++;
        $display("FAIL conflict_rsp4: id=%b f=%h, required id=%b f=%h", rsp_id, rsp_f, e.id, e.f);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_sel = SEL_XOR; req0_a = 32'hF0; req0_b = 32'hFF;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: ready0=%b, required 1", req0_ready);
    end
    push_exp(1'b0, SEL_XOR, 32'hF0, 32'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_sel = SEL_OR; req1_a = 32'd3; req1_b = 32'd4;
      #1;
      checks++;
      if ({rsp_valid, rsp_f, req0_ready, req1_ready} !== {1'b1, 32'h0F, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b f=%h ready0=%b ready1=%b, required 1 0000000f 0 0",
                 i, rsp_valid, rsp_f, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_refill: ready1=%b, required 1", req1_ready);
    end
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL bp_rsp0: rsp_valid=%b queued=%0d, required valid result", rsp_valid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
        errors++;
        $display("FAIL bp_rsp0: id=%b f=%h z=%b, required id=%b f=%h z=%b", rsp_id, rsp_f, rsp_z, e.id, e.f, e.z);
      end
    end
    push_exp(1'b1, SEL_OR, 32'd3, 32'd4);
    @(negedge clk);
    req1_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL bp_rsp1: rsp_valid=%b queued=%0d, required valid result", rsp_valid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
        errors++;
        $display("FAIL bp_rsp1: id=%b f=%h z=%b, required id=%b f=%h z=%b", rsp_id, rsp_f, rsp_z, e.id, e.f, e.z);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_undef_sel();
    req0_valid = 1'b1; req0_sel = 5'd31; req0_a = 32'd5; req0_b = 32'd5;
    push_exp(1'b0, 5'd31, 32'd5, 32'd5);
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
      errors++;
      $display("FAIL undef_rsp: rsp_valid=%b queued=%0d, required valid result", rsp_valid, sbq.size());
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
        errors++;
        $display("FAIL undef_rsp: id=%b f=%h z=%b, required id=%b f=%h z=%b", rsp_id, rsp_f, rsp_z, e.id, e.f, e.z);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
          errors++;
          $display("FAIL b2b_rsp%0d: rsp_valid=%b queued=%0d, required valid result", i, rsp_valid, sbq.size());
        end else begin
          e = sbq.pop_front();
          if ({rsp_id, rsp_f, rsp_z} !== {e.id, e.f, e.z}) begin
            errors++;
            $display("FAIL b2b_rsp%0d: id=%b f=%h z=%b, required id=%b f=%h z=%b", i, rsp_id, rsp_f, rsp_z, e.id, e.f, e.z);
          end
        end
      end
      if (i < 8) begin
        a = 32'hFFFF_0000 ^ (32'h1111_1111 * i);
        b = $urandom;
        req0_valid = 1'b1; req0_sel = SEL_AND; req0_a = a; req0_b = b;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready%0d: ready0=%b, required 1", i, req0_ready);
        end
        push_exp(1'b0, SEL_AND, a, b);
      end else begin
        req0_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midhold();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_sel = SEL_ADD; req0_a = 32'h1000; req0_b = 32'h0234;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_f} !== {1'b1, 32'h1234}) begin
      errors++;
      $display("FAIL midhold_full: valid=%b f=%h, required 1 00001234", rsp_valid, rsp_f);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_f} !== 33'd0) begin
      errors++;
      $display("FAIL midhold_async: valid=%b f=%h, required 0 00000000", rsp_valid, rsp_f);
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midhold_discard: rsp_valid=%b, required 0", rsp_valid);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_zero_flag();
    test_conflict();
    test_backpressure();
    test_undef_sel();
    test_back_to_back();
    test_reset_midhold();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries, required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
